// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the control sequencer: opcodes, tick indices, IR layout.
// Imported by ctrl_sequencer and onehot3to8.
package ctrl_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } opcode_e;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;

  localparam int IR_W  = 9;
  localparam int IR_OP = 6;
  localparam int IR_X  = 3;
  localparam int IR_Y  = 0;

endpackage

// File: rtl/ctrl_sequencer_onehot3to8.sv
// 3-bit register field to 8-bit one-hot select.
// Ports: i_sel (3-bit index), o_oh (one-hot, bit i_sel set).
module onehot3to8
  import ctrl_sequencer_pkg::*;
(
  input  logic [2:0] i_sel,
  output logic [7:0] o_oh
);

  assign o_oh = 8'b1 << i_sel;

endmodule

// File: rtl/ctrl_sequencer.sv
// Control sequencer: holds IR, decodes T0..T3 ticks into datapath controls,
// counts retired instructions. Optional macro TICK_CHECK_EN: strict one-hot
// tick checking with sticky tick_err. Ports: clk, rst (async, active-low),
// run, tick[3:0], din; controls ir_in, r_in, r_out, a_in, g_in, g_out,
// din_out, addsub, done, clear, illegal; status tick_err, instr_cnt.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [3:0]        tick,
  input  logic [DATA_W-1:0] din,
  output logic              ir_in,
  output logic [NREG-1:0]   r_in,
  output logic [NREG-1:0]   r_out,
  output logic              a_in,
  output logic              g_in,
  output logic              g_out,
  output logic              din_out,
  output logic              addsub,
  output logic              done,
  output logic              clear,
  output logic              illegal,
  output logic              tick_err,
  output logic [CNT_W-1:0]  instr_cnt
);

  logic [IR_W-1:0]  r_ir;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       w_t;
  logic [2:0]       w_op;
  logic [7:0]       w_xoh;
  logic [7:0]       w_yoh;
  logic             w_unused;

  assign w_unused = ^din[DATA_W-IR_W-1:0];

`ifdef TICK_CHECK_EN
  logic w_tick_ok;
  logic r_tick_err;

  // Any malformed tick suppresses every control for that cycle.
  assign w_tick_ok = $onehot(tick);
  assign w_t       = w_tick_ok ? tick : 4'b0000;
  assign tick_err  = r_tick_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_err <= 1'b0;
    end else if (!w_tick_ok) begin
      r_tick_err <= 1'b1;
    end
  end
`else
  // Keep only the lowest set bit; 0000 stays 0000 (idle).
  assign w_t      = tick & (~tick + 4'd1);
  assign tick_err = 1'b0;
`endif

  assign w_op = r_ir[IR_OP +: 3];

  onehot3to8 u_dec_x (
    .i_sel (r_ir[IR_X +: 3]),
    .o_oh  (w_xoh)
  );

  onehot3to8 u_dec_y (
    .i_sel (r_ir[IR_Y +: 3]),
    .o_oh  (w_yoh)
  );

  always_comb begin
    ir_in   = 1'b0;
    r_in    = '0;
    r_out   = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    din_out = 1'b0;
    addsub  = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    if (rst) begin
      unique case (1'b1)
        w_t[T0]: ir_in = run;
        w_t[T1]: begin
          unique case (w_op)
            OP_MV: begin
              r_out = w_yoh;
              r_in  = w_xoh;
              done  = 1'b1;
            end
            OP_MVI: begin
              din_out = 1'b1;
              r_in    = w_xoh;
              done    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              r_out = w_xoh;
              a_in  = 1'b1;
            end
            default: begin
              illegal = 1'b1;
              done    = 1'b1;
            end
          endcase
        end
        w_t[T2]: begin
          if (w_op == OP_ADD || w_op == OP_SUB) begin
            r_out  = w_yoh;
            g_in   = 1'b1;
            addsub = w_op[0];
          end
        end
        w_t[T3]: begin
          if (w_op == OP_ADD || w_op == OP_SUB) begin
            g_out = 1'b1;
            r_in  = w_xoh;
            done  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign clear     = done;
  assign instr_cnt = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir  <= '0;
      r_cnt <= '0;
    end else begin
      if (ir_in) begin
        r_ir <= din[DATA_W-1 -: IR_W];
      end
      if (done) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: directed + random ticks/instructions
// checked against a rule-level reference model.
module tb_ctrl_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b1;
  logic [3:0]    tick = 4'b0001;
  logic [15:0]   din = '0;
  logic          ir_in, a_in, g_in, g_out, din_out, addsub;
  logic          done, clear, illegal, tick_err;
  logic [7:0]    r_in, r_out;
  logic [CW-1:0] instr_cnt;

  ctrl_sequencer #(.DATA_W(16), .NREG(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .tick(tick), .din(din),
    .ir_in(ir_in), .r_in(r_in), .r_out(r_out), .a_in(a_in),
    .g_in(g_in), .g_out(g_out), .din_out(din_out), .addsub(addsub),
    .done(done), .clear(clear), .illegal(illegal),
    .tick_err(tick_err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [24:0]   o;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic [8:0]    m_ir = '0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_err = 1'b0;
  logic          p_rst = 1'b0;
  logic          p_ir_in = 1'b0;
  logic          p_done = 1'b0;
  logic          p_bad = 1'b0;
  logic [8:0]    p_din9 = '0;
  logic          last_done = 1'b0;

  function automatic bit bad_tick(logic [3:0] tk);
`ifdef TICK_CHECK_EN
    return $countones(tk) != 1;
`else
    return 1'b0;
`endif
  endfunction

  // Output vector: {ir_in, r_in, r_out, a_in, g_in, g_out, din_out,
  // addsub, done, clear, illegal}
  function automatic logic [24:0] model(bit rv, bit run_v,
                                        logic [3:0] tk, logic [8:0] ir);
    int t;
    int op, x, y;
    logic ld, a, gi, go, dout, as, dn, il;
    logic [7:0] ri, ro;
    t = -1;
    op = int'(ir[8:6]);
    x = int'(ir[5:3]);
    y = int'(ir[2:0]);
    ld = 0; a = 0; gi = 0; go = 0; dout = 0; as = 0; dn = 0; il = 0;
    ri = '0; ro = '0;
`ifdef TICK_CHECK_EN
    if ($countones(tk) == 1)
      for (int i = 0; i < 4; i++) if (tk[i]) t = i;
`else
    for (int i = 3; i >= 0; i--) if (tk[i]) t = i;
`endif
    if (rv) begin
      if (t == 0) begin
        ld = run_v;
      end else if (t == 1) begin
        if (op >= 4) begin
          il = 1; dn = 1;
        end else if (op == 0) begin
          ro = 8'd1 << y; ri = 8'd1 << x; dn = 1;
        end else if (op == 1) begin
          dout = 1; ri = 8'd1 << x; dn = 1;
        end else begin
          ro = 8'd1 << x; a = 1;
        end
      end else if (t == 2 && (op == 2 || op == 3)) begin
        ro = 8'd1 << y; gi = 1; as = (op == 3);
      end else if (t == 3 && (op == 2 || op == 3)) begin
        go = 1; ri = 8'd1 << x; dn = 1;
      end
    end
    return {ld, ri, ro, a, gi, go, dout, as, dn, dn, il};
  endfunction

  task automatic step(input bit rv, input bit run_v,
                      input logic [3:0] tk, input logic [15:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    if (p_rst) begin
      if (p_ir_in) m_ir = p_din9;
      if (p_done) m_cnt = m_cnt + 1'b1;
      if (p_bad) m_err = 1'b1;
    end
    rst = rv; run = run_v; tick = tk; din = d;
    if (!rv) begin
      m_ir = '0; m_cnt = '0; m_err = 1'b0;
    end
    e.o   = model(rv, run_v, tk, m_ir);
    e.cnt = m_cnt;
    e.err = m_err;
    q.push_back(e);
    p_rst   = rv;
    p_ir_in = e.o[24];
    p_done  = e.o[2];
    p_din9  = d[15:7];
    p_bad   = bad_tick(tk);
    last_done = e.o[2];
  endtask

  task automatic instr(input int op, input int x, input int y);
    logic [15:0] d;
    d = 16'($urandom);
    d[15:7] = {3'(op), 3'(x), 3'(y)};
    step(1, 1, 4'b0001, d);
    for (int t = 1; t < 4; t++) begin
      step(1, 0, 4'(1 << t), 16'($urandom));
      if (last_done) break;
    end
  endtask

  exp_t        mon_e;
  logic [24:0] mon_a;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = {ir_in, r_in, r_out, a_in, g_in, g_out, din_out,
               addsub, done, clear, illegal};
      checks++;
      if (mon_a !== mon_e.o) begin
        errors++;
        $display("FAIL outs t=%0t got=%h want=%h", $time, mon_a, mon_e.o);
      end
      checks++;
      if (instr_cnt !== mon_e.cnt) begin
        errors++;
        $display("FAIL instr_cnt t=%0t got=%0d want=%0d",
                 $time, instr_cnt, mon_e.cnt);
      end
      checks++;
      if (tick_err !== mon_e.err) begin
        errors++;
        $display("FAIL tick_err t=%0t got=%b want=%b",
                 $time, tick_err, mon_e.err);
      end
    end
  end

  int tseq;
  int r;

  initial begin
    step(0, 1, 4'b0001, 16'hFFFF);
    step(0, 1, 4'b0001, 16'hFFFF);
    step(1, 0, 4'b0001, 16'h0000);
    instr(1, 3, 0);
    instr(3, 2, 5);
    instr(2, 7, 1);
    instr(6, 1, 2);
    instr(0, 4, 4);
    instr(0, 1, 6);
    repeat (16) instr(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)));
    step(1, 1, 4'b0001, {3'd2, 3'd5, 3'd6, 7'd0});
    step(1, 0, 4'b0010, 16'h0);
    step(0, 0, 4'b0100, 16'h0);
    step(1, 0, 4'b0001, 16'h0);
    step(1, 0, 4'b0010, 16'h0);
`ifdef TICK_CHECK_EN
    step(1, 0, 4'b0110, 16'h0);
    step(1, 0, 4'b0001, 16'h0);
    step(1, 0, 4'b0001, 16'h0);
    step(0, 0, 4'b0001, 16'h0);
    step(1, 0, 4'b0001, 16'h0);
`else
    step(1, 0, 4'b1010, 16'h0);
    step(1, 0, 4'b1100, 16'h0);
    step(1, 0, 4'b0000, 16'h0);
`endif
    tseq = 0;
    repeat (3000) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        step(0, 1'($urandom), 4'($urandom), 16'($urandom));
        tseq = 0;
      end else if (r < 7) begin
        step(1, 1'($urandom), 4'($urandom), 16'($urandom));
        tseq = 0;
      end else if (tseq == 0) begin
        step(1, ($urandom_range(0, 3) != 0), 4'b0001, 16'($urandom));
        tseq = p_ir_in ? 1 : 0;
      end else begin
        step(1, 1'($urandom), 4'(1 << tseq), 16'($urandom));
        tseq = (last_done || tseq == 3) ? 0 : tseq + 1;
      end
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
